// File: rtl/instr_fetch_q.sv
// Instruction fetch unit: PC generation, 1-cycle memory requests, and a small {pc, instr} buffer to decode.
// Optional misaligned-redirect fault checking is enabled by defining IF_MISALIGN_CHK_EN.
module instr_fetch_q #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     ADDR_WIDTH = 10,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [XLEN-1:0]       imem_rdata,
    input  logic                  redirect,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [XLEN-1:0]       id_instr,
    output logic [XLEN-1:0]       id_pc,
    output logic                  fetch_fault
);

    localparam int unsigned    PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned    CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W+1)'(FIFO_DEPTH);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic             kill_q, kill_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0]  pc_mem_q    [FIFO_DEPTH];
    logic [XLEN-1:0]  instr_mem_q [FIFO_DEPTH];

    logic             pop, push, issue;
    logic [CNT_W:0]   occupancy, limit;

`ifdef IF_MISALIGN_CHK_EN
    assign fault_d = redirect ? (redirect_pc[1:0] != 2'b00) : fault_q;
`else
    assign fault_d = 1'b0;
`endif

    assign id_valid    = (count_q != '0);
    assign pop         = id_valid & id_ready;
    assign push        = inflight_q & ~kill_q & ~redirect;
    // Counting the in-flight request as occupied guarantees its response always has a slot.
    assign occupancy   = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    assign limit       = DEPTH_EXT + (CNT_W+1)'(pop);
    assign issue       = rst & ~redirect & ~fault_q & (occupancy < limit);

    assign imem_en     = issue;
    assign imem_addr   = fetch_pc_q[ADDR_WIDTH+1:2];
    assign id_instr    = instr_mem_q[rd_ptr_q];
    assign id_pc       = pc_mem_q[rd_ptr_q];
    assign fetch_fault = fault_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        kill_d        = redirect;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d      = wr_ptr_q + PTR_W'(push);
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
            fault_q       <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            kill_q        <= kill_d;
            fault_q       <= fault_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
                instr_mem_q[wr_ptr_q] <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_q.sv
// Bench for instr_fetch_q: cycle-exact vector table plus an in-order scoreboard on decode handshakes.
// Expectations for misaligned redirects follow IF_MISALIGN_CHK_EN.
module tb_instr_fetch_q;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    int hsCount = 0;
    logic [31:0] expQ [$];

    typedef struct {
        logic        rstN;
        logic        redir;
        logic [31:0] redirPc;
        logic        ready;
        logic        expEn;
        logic [9:0]  expAddr;
        logic        expValid;
        logic        chkPc;
        logic [31:0] expPc;
        logic        expFault;
    } vec_t;

    vec_t vecs [$];

    instr_fetch_q #(
        .XLEN(32), .ADDR_WIDTH(10), .RESET_PC(RST_PC), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // Memory word k holds 0xA000_0000 + k, returned one cycle after the request.
    always @(posedge clk) begin
        if (imem_en === 1'b1)
            imem_rdata <= 32'hA000_0000 + {22'b0, imem_addr};
    end

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return 32'hA000_0000 + {22'b0, pc[11:2]};
    endfunction

    function automatic vec_t mk(input logic rstN, input logic redir, input logic [31:0] rpc,
                                input logic ready, input logic en, input logic [9:0] addr,
                                input logic valid, input logic chk, input logic [31:0] pc,
                                input logic fault);
        vec_t v;
        v.rstN = rstN; v.redir = redir; v.redirPc = rpc; v.ready = ready;
        v.expEn = en; v.expAddr = addr; v.expValid = valid; v.chkPc = chk;
        v.expPc = pc; v.expFault = fault;
        return v;
    endfunction

    task automatic restartStream(input logic [31:0] target);
        expQ.delete();
        for (int i = 0; i < 400; i++) expQ.push_back(target + 32'(4 * i));
    endtask

    task automatic checkVal(input string name, input int idx, input logic [31:0] got,
                            input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s (row %0d): got %h, want %h", name, idx, got, want);
        end
    endtask

    // Every accepted instruction must be the next one of the current expected stream.
    always @(negedge clk) begin
        if (rst === 1'b1 && redirect === 1'b0 && id_valid === 1'b1 && id_ready === 1'b1) begin
            hsCount++;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got pc %h, want no instruction", id_pc);
            end else begin
                logic [31:0] e;
                e = expQ.pop_front();
                if (id_pc !== e || id_instr !== instrOf(e)) begin
                    errors++;
                    $display("[TB] FAIL sb_order: got pc %h instr %h, want pc %h instr %h",
                             id_pc, id_instr, e, instrOf(e));
                end
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst         = v.rstN;
        redirect    = v.redir;
        redirect_pc = v.redirPc;
        id_ready    = v.ready;
        if (!v.rstN) begin
            restartStream(RST_PC);
        end else if (v.redir) begin
`ifdef IF_MISALIGN_CHK_EN
            if (v.redirPc[1:0] != 2'b00) expQ.delete();
            else restartStream(v.redirPc);
`else
            restartStream(v.redirPc & 32'hFFFF_FFFC);
`endif
        end
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        #1;
        checkVal("imem_en", idx, {31'b0, imem_en}, {31'b0, v.expEn});
        if (v.expEn) checkVal("imem_addr", idx, {22'b0, imem_addr}, {22'b0, v.expAddr});
        checkVal("id_valid", idx, {31'b0, id_valid}, {31'b0, v.expValid});
        if (v.chkPc) begin
            checkVal("id_pc", idx, id_pc, v.expPc);
            checkVal("id_instr", idx, id_instr, v.expValid ? instrOf(v.expPc) : 32'h0);
        end
        checkVal("fetch_fault", idx, {31'b0, fetch_fault}, {31'b0, v.expFault});
    endtask

    initial begin
        int hsStart;
        vec_t r;
        logic mf;
`ifdef IF_MISALIGN_CHK_EN
        mf = 1'b1;
`else
        mf = 1'b0;
`endif
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        restartStream(RST_PC);
        repeat (2) @(posedge clk);

        //         rstN redir rpc           rdy en addr    val chk pc            fault
        vecs.push_back(mk(0, 0, 32'h0,   1, 0, 10'h0,   0, 1, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h40,  0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h41,  0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h42,  1, 1, 32'h100, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h43,  1, 1, 32'h104, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 32'h0, 0, 0, 10'h0, 1, 1, 32'h108, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h44,  1, 1, 32'h108, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h45,  1, 1, 32'h10C, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h46,  1, 1, 32'h110, 0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 0, 10'h0,   1, 1, 32'h114, 0));
        vecs.push_back(mk(1, 1, 32'h200, 1, 0, 10'h0,   1, 1, 32'h114, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h80,  0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h81,  0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h82,  1, 1, 32'h200, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h83,  1, 1, 32'h204, 0));
        vecs.push_back(mk(1, 1, 32'h300, 1, 0, 10'h0,   1, 1, 32'h208, 0));
        vecs.push_back(mk(1, 1, 32'h400, 1, 0, 10'h0,   0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h100, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h101, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h102, 1, 1, 32'h400, 0));
        vecs.push_back(mk(1, 1, 32'h302, 1, 0, 10'h0,   1, 1, 32'h404, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, !mf, 10'hC0, 0, 0, 32'h0,  mf));
        vecs.push_back(mk(1, 0, 32'h0,   1, !mf, 10'hC1, 0, 0, 32'h0,  mf));
        vecs.push_back(mk(1, 1, 32'h310, 1, 0, 10'h0,   !mf, !mf, 32'h300, mf));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'hC4,  0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'hC5,  0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'hC6,  1, 1, 32'h310, 0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0, 10'h0,   1, 1, 32'h314, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h40,  0, 1, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h41,  0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h42,  1, 1, 32'h100, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 1, 10'h43,  1, 1, 32'h104, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            r = vecs[i];
            applyStimulus(r);
            checkOutput(r, i);
        end

        // Random decode back-pressure with one aligned redirect midway; order is checked by the scoreboard.
        hsStart = hsCount;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            id_ready = ($urandom_range(0, 1) == 1);
            if (c == 150) begin
                redirect    = 1'b1;
                redirect_pc = {18'b0, 12'($urandom_range(0, 1023)), 2'b00};
                restartStream(redirect_pc);
            end else begin
                redirect = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        id_ready = 1'b0;
        redirect = 1'b0;
        checks++;
        if (hsCount - hsStart < 60) begin
            errors++;
            $display("[TB] FAIL throughput: got %0d handshakes, want at least 60", hsCount - hsStart);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
